// File: rtl/sram_arb_pkg.sv
// Shared types and defaults for the two-port SRAM arbiter.
package sram_arb_pkg;

   typedef logic port_id_t;

   localparam int DEF_DEPTH    = 3072;
   localparam int DEF_MAX_LOCK = 8;

   // Byte-enable pattern that marks a read (default DW = 32).
   localparam logic [3:0] READ = '0;

endpackage

// File: rtl/rr_lock_sched.sv
// Round-robin scheduler for two requesters with a bounded priority lock.
module rr_lock_sched
   import sram_arb_pkg::*;
#(
   parameter int MAX_LOCK = DEF_MAX_LOCK
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   input  logic [1:0] lock,
   output logic [1:0] grant
);

   localparam int CW = $clog2(MAX_LOCK + 1);

   port_id_t         last;
   port_id_t         last_nxt;
   logic [CW-1:0]    lock_cnt;
   logic [CW-1:0]    lock_cnt_nxt;
   logic             last_lock;
   logic             last_lock_nxt;
   port_id_t         gnt_port;

   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= 1'b1;
         lock_cnt  <= '0;
         last_lock <= 1'b0;
      end else begin
         last      <= last_nxt;
         lock_cnt  <= lock_cnt_nxt;
         last_lock <= last_lock_nxt;
      end
   end

   assign gnt_port = grant[1];

   always_comb begin
      last_nxt      = last;
      lock_cnt_nxt  = '0;
      last_lock_nxt = last_lock;
      if (grant != 2'b00) begin
         last_lock_nxt = lock[gnt_port];
         if (gnt_port == last) begin
            lock_cnt_nxt = (lock_cnt < CW'(MAX_LOCK)) ? lock_cnt + 1'b1 : lock_cnt;
         end else begin
            lock_cnt_nxt = CW'(1);
            last_nxt     = gnt_port;
         end
      end
   end

   // The lock only holds priority while the other port is actually waiting.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         case (valid)
            2'b01: grant = 2'b01;
            2'b10: grant = 2'b10;
            2'b11: begin
               if (last_lock && (lock_cnt < CW'(MAX_LOCK)))
                  grant = last ? 2'b10 : 2'b01;
               else
                  grant = last ? 2'b01 : 2'b10;
            end
            default: grant = 2'b00;
         endcase
      end
   end

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-ported SRAM between two requesters; routes read data
// back one cycle later and flags accesses beyond the populated depth.
module sram_port_arbiter
   import sram_arb_pkg::*;
#(
   parameter int AW       = 12,
   parameter int DW       = 32,
   parameter int DEPTH    = DEF_DEPTH,
   parameter int MAX_LOCK = DEF_MAX_LOCK
)
(
   input  logic            HCLK,
   input  logic            HRESET,
   input  logic            p0_valid,
   output logic            p0_ready,
   input  logic [AW-1:0]   p0_addr,
   input  logic [DW/8-1:0] p0_wen,
   input  logic [DW-1:0]   p0_wdata,
   input  logic            p0_lock,
   output logic            p0_rvalid,
   output logic [DW-1:0]   p0_rdata,
   output logic            p0_err,
   input  logic            p1_valid,
   output logic            p1_ready,
   input  logic [AW-1:0]   p1_addr,
   input  logic [DW/8-1:0] p1_wen,
   input  logic [DW-1:0]   p1_wdata,
   input  logic            p1_lock,
   output logic            p1_rvalid,
   output logic [DW-1:0]   p1_rdata,
   output logic            p1_err,
   output logic            SRAMCS0,
   output logic [DW/8-1:0] SRAMWEN,
   output logic [AW-1:0]   SRAMADDR,
   output logic [DW-1:0]   SRAMWDATA,
   input  logic [DW-1:0]   SRAMRDATA
);

   localparam int BW = DW / 8;
   localparam logic [BW-1:0] WEN_READ = BW'(READ);

   logic [1:0]    grant;
   port_id_t      gnt_port;
   logic          accept;
   logic          oor;
   logic          is_read;
   logic [BW-1:0] sel_wen;

   port_id_t      rd_port;
   logic          rd_pend;
   logic          rd_oor;
   port_id_t      err_port;
   logic          err_pend;
   logic          live;
   logic [DW-1:0] ret_data;

   rr_lock_sched #(.MAX_LOCK(MAX_LOCK)) u_sched (
      .clk   (HCLK),
      .rst   (HRESET),
      .valid ({p1_valid, p0_valid}),
      .lock  ({p1_lock, p0_lock}),
      .grant (grant)
   );

   assign p0_ready = grant[0];
   assign p1_ready = grant[1];
   assign gnt_port = grant[1];
   assign accept   = |grant;

   // With no grant the pins simply follow port 0.
   assign SRAMADDR  = gnt_port ? p1_addr  : p0_addr;
   assign SRAMWDATA = gnt_port ? p1_wdata : p0_wdata;
   assign sel_wen   = gnt_port ? p1_wen   : p0_wen;
   assign is_read   = (sel_wen == WEN_READ);
   assign oor       = ({1'b0, SRAMADDR} >= (AW + 1)'(DEPTH));

   assign SRAMCS0 = accept & ~oor;
   assign SRAMWEN = SRAMCS0 ? sel_wen : '0;

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         rd_pend  <= 1'b0;
         rd_oor   <= 1'b0;
         rd_port  <= 1'b0;
         err_pend <= 1'b0;
         err_port <= 1'b0;
      end else begin
         rd_pend  <= accept & is_read;
         rd_oor   <= oor;
         rd_port  <= gnt_port;
         err_pend <= accept & oor;
         err_port <= gnt_port;
      end
   end

   // Returns are masked while reset is held so an in-flight read is dropped.
   assign live     = ~HRESET;
   assign ret_data = rd_oor ? '0 : SRAMRDATA;

   assign p0_rvalid = live & rd_pend & (rd_port == 1'b0);
   assign p1_rvalid = live & rd_pend & (rd_port == 1'b1);
   assign p0_rdata  = p0_rvalid ? ret_data : '0;
   assign p1_rdata  = p1_rvalid ? ret_data : '0;
   assign p0_err    = live & err_pend & (err_port == 1'b0);
   assign p1_err    = live & err_pend & (err_port == 1'b1);

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Self-checking bench for sram_port_arbiter with a behavioural SRAM and a
// return-path scoreboard.
module tb_sram_port_arbiter;

   typedef struct packed {
      logic        rv0;
      logic        rv1;
      logic        er0;
      logic        er1;
      logic [31:0] rd0;
      logic [31:0] rd1;
   } ret_t;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        p0_valid, p1_valid;
   logic        p0_ready, p1_ready;
   logic [11:0] p0_addr, p1_addr;
   logic [3:0]  p0_wen, p1_wen;
   logic [31:0] p0_wdata, p1_wdata;
   logic        p0_lock, p1_lock;
   logic        p0_rvalid, p1_rvalid;
   logic [31:0] p0_rdata, p1_rdata;
   logic        p0_err, p1_err;
   logic        SRAMCS0;
   logic [3:0]  SRAMWEN;
   logic [11:0] SRAMADDR;
   logic [31:0] SRAMWDATA;
   logic [31:0] SRAMRDATA;

   int checks   = 0;
   int failures = 0;
   bit mon_en   = 1'b0;

   logic [31:0] mem     [0:4095];
   bit          mem_wr  [0:4095];
   logic [31:0] ref_mem [0:4095];
   bit          ref_wr  [0:4095];
   ret_t        sb[$];

   sram_port_arbiter u_dut (
      .HCLK      (HCLK),      .HRESET    (HRESET),
      .p0_valid  (p0_valid),  .p0_ready  (p0_ready),  .p0_addr  (p0_addr),
      .p0_wen    (p0_wen),    .p0_wdata  (p0_wdata),  .p0_lock  (p0_lock),
      .p0_rvalid (p0_rvalid), .p0_rdata  (p0_rdata),  .p0_err   (p0_err),
      .p1_valid  (p1_valid),  .p1_ready  (p1_ready),  .p1_addr  (p1_addr),
      .p1_wen    (p1_wen),    .p1_wdata  (p1_wdata),  .p1_lock  (p1_lock),
      .p1_rvalid (p1_rvalid), .p1_rdata  (p1_rdata),  .p1_err   (p1_err),
      .SRAMCS0   (SRAMCS0),   .SRAMWEN   (SRAMWEN),   .SRAMADDR (SRAMADDR),
      .SRAMWDATA (SRAMWDATA), .SRAMRDATA (SRAMRDATA)
   );

   always #5 HCLK = ~HCLK;

   function automatic logic [31:0] preload(input logic [11:0] a);
      return {a, 4'h5, ~a, 4'hA};
   endfunction

   // Behavioural SRAM: byte writes complete at the edge, reads return next cycle.
   always @(posedge HCLK) begin
      if (SRAMCS0) begin
         logic [31:0] cur;
         cur = mem_wr[SRAMADDR] ? mem[SRAMADDR] : preload(SRAMADDR);
         if (SRAMWEN == 4'b0000) begin
            SRAMRDATA <= cur;
         end else begin
            for (int b = 0; b < 4; b++)
               if (SRAMWEN[b]) cur[8*b +: 8] = SRAMWDATA[8*b +: 8];
            mem[SRAMADDR]    <= cur;
            mem_wr[SRAMADDR] <= 1'b1;
         end
      end
   end

   function automatic ret_t rec_access(input int p, input logic [11:0] a, input logic [3:0] w,
                                       input logic [31:0] d, input ret_t e);
      ret_t        r;
      logic [31:0] cur;
      bit          oor;
      r   = e;
      oor = (a >= 12'd3072);
      cur = ref_wr[a] ? ref_mem[a] : preload(a);
      if (w == 4'b0000) begin
         if (p == 0) begin r.rv0 = 1'b1; r.rd0 = oor ? 32'h0 : cur; end
         else        begin r.rv1 = 1'b1; r.rd1 = oor ? 32'h0 : cur; end
      end else if (!oor) begin
         for (int b = 0; b < 4; b++)
            if (w[b]) cur[8*b +: 8] = d[8*b +: 8];
         ref_mem[a] = cur;
         ref_wr[a]  = 1'b1;
      end
      if (oor) begin
         if (p == 0) r.er0 = 1'b1;
         else        r.er1 = 1'b1;
      end
      return r;
   endfunction

   // Scoreboard: compare last cycle's return, then record this cycle's acceptance.
   always @(negedge HCLK) begin
      if (mon_en) begin
         ret_t exp_r, act_r, nxt;
         exp_r = '0;
         if (HRESET) sb.delete();
         else if (sb.size() > 0) exp_r = sb.pop_front();
         act_r = {p0_rvalid, p1_rvalid, p0_err, p1_err, p0_rdata, p1_rdata};
         checks++;
         if (act_r !== exp_r) begin
            failures++;
            $display("FAIL return_path t=%0t got=%h want=%h", $time, act_r, exp_r);
         end
         if (!HRESET && ((p0_valid && p0_ready) || (p1_valid && p1_ready))) begin
            nxt = '0;
            if (p0_valid && p0_ready) nxt = rec_access(0, p0_addr, p0_wen, p0_wdata, nxt);
            if (p1_valid && p1_ready) nxt = rec_access(1, p1_addr, p1_wen, p1_wdata, nxt);
            sb.push_back(nxt);
         end
      end
   end

   task automatic set_p(input int p, input logic v, input logic [11:0] a, input logic [3:0] w,
                        input logic [31:0] d, input logic l);
      if (p == 0) begin
         p0_valid = v; p0_addr = a; p0_wen = w; p0_wdata = d; p0_lock = l;
      end else begin
         p1_valid = v; p1_addr = a; p1_wen = w; p1_wdata = d; p1_lock = l;
      end
   endtask

   task automatic test_reset();
      HRESET = 1'b1;
      set_p(0, 1'b1, 12'h010, 4'h0, 32'h0, 1'b0);
      set_p(1, 1'b1, 12'h010, 4'h0, 32'h0, 1'b0);
      @(posedge HCLK); #1 mon_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checks++;
         if ({p1_ready, p0_ready, SRAMCS0, SRAMWEN} !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle got ready=%b%b cs=%b wen=%h want 0", p1_ready, p0_ready, SRAMCS0, SRAMWEN);
         end
         @(posedge HCLK); #1;
      end
   endtask

   task automatic test_reset_priority();
      logic [31:0] d;
      d = preload(12'h010);
      HRESET = 1'b0;
      @(negedge HCLK);
      checks++;
      if ({p1_ready, p0_ready} !== 2'b01) begin
         failures++; $display("FAIL first_grant got=%b%b want=01", p1_ready, p0_ready);
      end
      @(posedge HCLK); #1 set_p(0, 1'b0, 12'h010, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if ({p1_ready, p0_ready} !== 2'b10 || p0_rvalid !== 1'b1 || p0_rdata !== d) begin
         failures++;
         $display("FAIL second_grant got rdy=%b%b rv0=%b rd0=%h want rdy=10 rv0=1 rd0=%h", p1_ready, p0_ready, p0_rvalid, p0_rdata, d);
      end
      @(posedge HCLK); #1 set_p(1, 1'b0, 12'h010, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== d || p0_rvalid !== 1'b0) begin
         failures++;
         $display("FAIL p1_return got rv1=%b rd1=%h rv0=%b want rv1=1 rd1=%h rv0=0", p1_rvalid, p1_rdata, p0_rvalid, d);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] pre, want;
      pre  = preload(12'h123);
      want = {pre[31:16], 16'hBEEF};
      @(posedge HCLK); #1 set_p(1, 1'b1, 12'h123, 4'b0011, 32'hDEADBEEF, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p1_ready !== 1'b1 || SRAMCS0 !== 1'b1 || SRAMWEN !== 4'b0011) begin
         failures++; $display("FAIL b2b_write got rdy=%b cs=%b wen=%b want 1 1 0011", p1_ready, SRAMCS0, SRAMWEN);
      end
      @(posedge HCLK); #1 set_p(1, 1'b1, 12'h123, 4'b0000, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p1_ready !== 1'b1 || SRAMCS0 !== 1'b1 || SRAMWEN !== 4'b0000) begin
         failures++; $display("FAIL b2b_read_nobubble got rdy=%b cs=%b wen=%b want 1 1 0000", p1_ready, SRAMCS0, SRAMWEN);
      end
      @(posedge HCLK); #1 set_p(1, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p1_rvalid !== 1'b1 || p1_rdata !== want) begin
         failures++; $display("FAIL b2b_data got rv=%b rd=%h want rv=1 rd=%h", p1_rvalid, p1_rdata, want);
      end
   endtask

   task automatic test_round_robin();
      logic [11:0] a0, a1;
      int          exp_p;
      a0 = 12'h020;
      a1 = 12'h040;
      for (int i = 0; i < 6; i++) begin
         exp_p = i % 2;
         @(posedge HCLK); #1;
         set_p(0, 1'b1, a0, 4'h0, 32'h0, 1'b0);
         set_p(1, 1'b1, a1, 4'h0, 32'h0, 1'b0);
         @(negedge HCLK);
         checks++;
         if ({p1_ready, p0_ready} !== ((exp_p == 1) ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL rr_grant%0d got=%b%b want port %0d", i, p1_ready, p0_ready, exp_p);
         end
         if (exp_p == 0) a0 = a0 + 12'd1;
         else            a1 = a1 + 12'd1;
      end
      @(posedge HCLK); #1;
      set_p(0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      set_p(1, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(posedge HCLK); #1;
   endtask

   task automatic test_lock_bound();
      int exp_p;
      for (int i = 0; i < 9; i++) begin
         exp_p = (i < 8) ? 0 : 1;
         @(posedge HCLK); #1;
         set_p(0, 1'b1, 12'h080 + 12'(i), 4'hF, 32'h1000_0000 + i, 1'b1);
         set_p(1, 1'b1, 12'h0A0, 4'h0, 32'h0, 1'b0);
         @(negedge HCLK);
         checks++;
         if ({p1_ready, p0_ready} !== ((exp_p == 1) ? 2'b10 : 2'b01)) begin
            failures++; $display("FAIL lock_grant%0d got=%b%b want port %0d", i, p1_ready, p0_ready, exp_p);
         end
      end
      @(posedge HCLK); #1;
      set_p(0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      set_p(1, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (u_dut.u_sched.lock_cnt !== 4'd1) begin
         failures++; $display("FAIL lock_cnt_after got=%0d want=1", u_dut.u_sched.lock_cnt);
      end
   endtask

   task automatic test_out_of_range();
      logic [31:0] d;
      d = preload(12'hBFF);
      @(posedge HCLK); #1 set_p(0, 1'b1, 12'hC00, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p0_ready !== 1'b1 || SRAMCS0 !== 1'b0) begin
         failures++; $display("FAIL oor_read_pins got rdy=%b cs=%b want rdy=1 cs=0", p0_ready, SRAMCS0);
      end
      @(posedge HCLK); #1 set_p(0, 1'b1, 12'hFFF, 4'hF, 32'h12345678, 1'b0);
      @(negedge HCLK);
      checks++;
      if (SRAMCS0 !== 1'b0 || SRAMWEN !== 4'h0 || p0_rvalid !== 1'b1 || p0_err !== 1'b1 || p0_rdata !== 32'h0) begin
         failures++;
         $display("FAIL oor_read_ret got cs=%b wen=%h rv=%b err=%b rd=%h want cs=0 wen=0 rv=1 err=1 rd=0", SRAMCS0, SRAMWEN, p0_rvalid, p0_err, p0_rdata);
      end
      @(posedge HCLK); #1 set_p(0, 1'b1, 12'hBFF, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (SRAMCS0 !== 1'b1 || p0_err !== 1'b1 || p0_rvalid !== 1'b0) begin
         failures++; $display("FAIL oor_write_ret got cs=%b err=%b rv=%b want cs=1 err=1 rv=0", SRAMCS0, p0_err, p0_rvalid);
      end
      @(posedge HCLK); #1 set_p(0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p0_rvalid !== 1'b1 || p0_err !== 1'b0 || p0_rdata !== d || mem_wr[4095] !== 1'b0) begin
         failures++;
         $display("FAIL last_word got rv=%b err=%b rd=%h touched=%b want rv=1 err=0 rd=%h touched=0", p0_rvalid, p0_err, p0_rdata, mem_wr[4095], d);
      end
   endtask

   task automatic test_reset_mid_read();
      @(posedge HCLK); #1 set_p(1, 1'b1, 12'h055, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p1_ready !== 1'b1) begin
         failures++; $display("FAIL rmr_accept got=%b want=1", p1_ready);
      end
      @(posedge HCLK); #1;
      HRESET = 1'b1;
      set_p(0, 1'b1, 12'h055, 4'h0, 32'h0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         @(negedge HCLK);
         checks++;
         if (p1_rvalid !== 1'b0 || p1_err !== 1'b0 || SRAMCS0 !== 1'b0 || {p1_ready, p0_ready} !== 2'b00) begin
            failures++;
            $display("FAIL rmr_in_reset%0d got rv=%b err=%b cs=%b rdy=%b%b want all 0", i, p1_rvalid, p1_err, SRAMCS0, p1_ready, p0_ready);
         end
         @(posedge HCLK); #1;
      end
      HRESET = 1'b0;
      set_p(1, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p0_ready !== 1'b1) begin
         failures++; $display("FAIL rmr_after_reset got=%b want=1", p0_ready);
      end
      @(posedge HCLK); #1 set_p(0, 1'b0, 12'h0, 4'h0, 32'h0, 1'b0);
      @(negedge HCLK);
      checks++;
      if (p0_rvalid !== 1'b1 || p0_rdata !== preload(12'h055) || p1_rvalid !== 1'b0) begin
         failures++; $display("FAIL rmr_recovery got rv0=%b rd0=%h rv1=%b want 1 %h 0", p0_rvalid, p0_rdata, p1_rvalid, preload(12'h055));
      end
      @(posedge HCLK); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      test_reset();
      test_reset_priority();
      test_back_to_back();
      test_round_robin();
      test_lock_bound();
      test_out_of_range();
      test_reset_mid_read();
      repeat (2) @(posedge HCLK);
      @(negedge HCLK); #1;
      checks++;
      if (sb.size() != 0) begin
         failures++; $display("FAIL sb_drain got=%0d want=0", sb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
# sram_port_arbiter

Two-port arbiter that shares the single-ported 3K×32 on-chip SRAM between the CPU-side AHB SRAM interface (port 0) and a secondary bus master such as the UART master or a DMA engine (port 1). It schedules one access per cycle using round-robin with a bounded lock, and drives the SRAM macro pins directly. It routes the one-cycle-latency read data back to the port that issued the access, and flags accesses outside the populated depth.

## Interface
- `AW`, 12: word-address width.
- `DW`, 32: data width. Byte-enable width is `DW/8`.
- `DEPTH`, 3072: populated words. Addresses `>= DEPTH` are out of range.
- `MAX_LOCK`, 8: maximum consecutive grants to one port while the other port is waiting.
- `HCLK`, in, 1: single clock.
- `HRESET`, in, 1: reset, synchronous and active-high.
- `p0_valid` / `p1_valid`, in, 1: request present.
- `p0_ready` / `p1_ready`, out, 1: request accepted this cycle.
- `p0_addr` / `p1_addr`, in, AW: word address.
- `p0_wen` / `p1_wen`, in, DW/8: byte write enables. All-zero means read.
- `p0_wdata` / `p1_wdata`, in, DW: write data.
- `p0_lock` / `p1_lock`, in, 1: request priority for the next cycle.
- `p0_rvalid` / `p1_rvalid`, out, 1: read data valid.
- `p0_rdata` / `p1_rdata`, out, DW: read data.
- `p0_err` / `p1_err`, out, 1: one-cycle pulse for an out-of-range access.
- `SRAMCS0`, out, 1: SRAM enable.
- `SRAMWEN`, out, DW/8: SRAM byte write enables.
- `SRAMADDR`, out, AW: SRAM address.
- `SRAMWDATA`, out, DW: SRAM write data.
- `SRAMRDATA`, in, DW: SRAM read data, valid one cycle after the enabling edge.

## Operation
- **Handshake.** A transfer happens when `px_valid & px_ready`. At most one `ready` is high per cycle, and `ready` is a combinational grant. A requester holds `addr`, `wen` and `wdata` stable until it sees `ready`.
- **Arbitration state.** `last` (1 bit) records the most recently granted port. `lock_cnt` (`$clog2(MAX_LOCK+1)` bits) counts consecutive grants.
- **Grant rules, evaluated in order:**
  - Only one port is valid: grant it.
  - Both are valid, `plast_lock` was high on `last`'s previous accepted transfer, and `lock_cnt < MAX_LOCK`: grant `last`.
  - Otherwise: grant `~last` (round-robin).
- **Lock counter.**
  - On a grant to the same port as `last`: `lock_cnt` increments, saturating at `MAX_LOCK`.
  - On a grant to the other port: `lock_cnt` = 1 and `last` is updated.
  - On an idle cycle: `lock_cnt` = 0 and `last` is kept.
- **In-range accepted transfer.**
  - `SRAMCS0` = 1, and `SRAMADDR`, `SRAMWEN`, `SRAMWDATA` come from the granted port.
  - A read (`wen == 0`) sets the return-tag flops `rd_pend` = 1 and `rd_port` = granted port.
- **Out-of-range accepted transfer.** `SRAMCS0` = 0 and `SRAMWEN` = 0, so the SRAM is not touched. Set `err_pend` = 1 and `err_port` = granted port.
- **No transfer.** `SRAMCS0` = 0, `SRAMWEN` = 0. `SRAMADDR` and `SRAMWDATA` are don't-care; the RTL drives port 0's values.
- **Return path.**
  - `prd_port_rvalid` = `rd_pend`, and `prd_port_rdata` = `SRAMRDATA`.
  - The other port's `rdata` is 0.
  - An out-of-range read gives `rvalid` = 1, `rdata` = 0 and `err` = 1.
  - An out-of-range write gives only `err` = 1.
- **Simultaneous events.** A new request may be accepted in the same cycle as the return of the previous one, so throughput is 1 access per cycle with no bubbles.
- **Reset.**
  - `last` = 1, so port 0 wins the first contention.
  - `lock_cnt` = 0.
  - `rd_pend` and `err_pend` = 0.
  - While `HRESET` is high, both `ready` are 0 and `SRAMCS0` = 0.
  - Reset asserted mid-access drops the pending return: no `rvalid` or `err` in the cycle after reset.

## Timing
- The SRAM pins are combinational from the grant in cycle N.
- Read data, `rvalid` and `err` appear in cycle N+1 and are registered-tag qualified.
- Write latency is 0: the write is complete at the accepting edge.
- Reset values:
  - `rvalid`, `err` and `rdata` = 0.
  - `SRAMCS0` = 0 and `SRAMWEN` = 0.
  - `ready` = 0.
- The `ready` → `valid` combinational path is forbidden in requesters.

## Structure
- Package `sram_arb_pkg`:
  - a `port_id_t` 1-bit typedef;
  - `DEPTH` and `MAX_LOCK` defaults;
  - the localparam `READ = '0` for `wen`.
- One sub-module, `rr_lock_sched`: it takes the two `valid` and two `lock` inputs and produces the one-hot `grant`. It contains `last` and `lock_cnt`.
- The top level holds the SRAM muxing, the range check and the return tag.

## Test plan
- **Reset priority.** After reset, both ports read 0x010 in the same cycle. Required: `p0_ready` = 1 first, then `p1_ready` the next cycle; `p0_rvalid` in N+1 and `p1_rvalid` in N+2 with the preloaded data.
- **Back-to-back write/read.** Port 1 writes 0xDEADBEEF with `wen` = 4'b0011 to 0x123, then reads it on the next cycle. Required: `rdata` = 0xXXXXBEEF with the upper bytes preserved, and no bubble between the two accesses.
- **Round-robin fairness.** Both ports are valid for 6 cycles with lock = 0. Required: grants alternate 0,1,0,1,0,1, and each `rvalid` goes only to its owner.
- **Lock bound.** `p0_lock` = 1 and both ports are continuously valid. Required: port 0 gets exactly 8 consecutive grants, then port 1 is granted, and `lock_cnt` returns to 1.
- **Out of range.** Port 0 reads 0xC00 (3072). Required: `SRAMCS0` stays 0; next cycle `p0_rvalid` = 1, `p0_err` = 1, `p0_rdata` = 0. A write to 0xFFF gives `err` only, and the memory contents are unchanged.
- **Reset mid-read.** Port 1 read accepted in cycle N with `HRESET` asserted at N+1. Required: `p1_rvalid` = 0 at N+1, and `SRAMCS0` = 0 throughout reset.
